prince_state_router: RTL and testbench
======================================

# prince_state_router

Sequential counterpart of the 64-bit round-input selector in the PRINCE datapath. The selector steers fresh input or the feedback state into the round logic. This block sits at the round-logic output and does three things: drives the selector's `sel`, and routes each round result to the feedback register or to a held output register. A round counter and an in/out valid–ready handshake sequence one encryption at a time over `ROUNDS` single-cycle round iterations.

## Interface
- `WIDTH`, 64, state width (per share; instantiated once per share group).
- `ROUNDS`, 12, round iterations per encryption; legal range 2..15.
- `CNT_W`, 4, round counter width; must satisfy 2^CNT_W > ROUNDS.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers new input on selector `t` leg.
- `in_ready`  out  1  block accepts new input (IDLE only).
- `sel`  out  1  selector control: 1 = fresh input `t`, 0 = feedback `f`.
- `d`  in  WIDTH  combinational round-logic result of current selector output.
- `fb`  out  WIDTH  feedback state, wired to selector `f` leg.
- `round_idx`  out  CNT_W  current round index for round-constant lookup.
- `out_data`  out  WIDTH  final state, held stable while `out_valid`.
- `out_valid`  out  1  final state available.
- `out_ready`  in  1  downstream accepts `out_data`.
- `flush`  in  1  synchronous abort to IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1, `sel`=1, `round_idx`=0.
  - On `in_valid`: `fb` <= `d` (round 0 applied to `t`), counter <= 1, go to RUN.
- RUN:
  - `in_ready`=0, `sel`=0, `round_idx`=counter.
  - Each cycle: `fb` <= `d`, counter <= counter+1.
  - When counter == ROUNDS-1: `out_data` <= `d`, `out_valid` <= 1, go to DONE; `fb` is also updated.
- DONE:
  - `in_ready`=0, `sel`=1, `out_data` frozen.
  - On `out_ready`: `out_valid` <= 0, go to IDLE.
- Counter arithmetic: unsigned, CNT_W bits. It never wraps because it is terminated at ROUNDS-1.
- `flush` (priority over every transition): state <= IDLE, `out_valid` <= 0, counter <= 0. `fb` and `out_data` keep their values. An input offered in the same cycle as `flush` is not accepted.
- Reset: state IDLE, counter 0, `fb`=0, `out_data`=0, `out_valid`=0. Combinational outputs follow IDLE: `in_ready`=1, `sel`=1, `round_idx`=0.
- Reset mid-RUN or mid-DONE discards the operation immediately; no output is produced.

## Timing
- Input handshake completes at edge E0 (`in_valid` & `in_ready`).
- `out_valid` rises after edge E0+ROUNDS-1, i.e. ROUNDS-1 cycles later.
- Total rounds applied to the data: exactly ROUNDS.
- Output handshake completes on an edge where `out_valid` & `out_ready`. `in_ready` is 1 the following cycle.
- Minimum issue interval: ROUNDS+1 cycles (one IDLE cycle is mandatory).
- `out_ready` held high early has no effect until DONE.
- `in_valid` held during RUN/DONE is ignored, not queued.
- `in_ready`, `sel` and `round_idx` are decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Shared package `prince_pkg`:
  - FSM state encoding (IDLE/RUN/DONE).
  - Default `ROUNDS` and `CNT_W` constants.
  - `WIDTH`=64 state-width constant.
- Sub-module `round_counter`: load-1, increment, and terminal-count flag at ROUNDS-1.
- FSM and registers stay in the top.

## Test plan
Bench model: `d` = (`sel` ? `t` : `fb`) + 1, ROUNDS=12.
- Reset -> `in_ready`=1, `sel`=1, `out_valid`=0, `fb`=0, `out_data`=0.
- `t`=0x100 accepted, `out_ready`=1 -> `out_valid` 11 cycles after acceptance, `out_data`=0x10C; `round_idx` steps 1..11 during RUN.
- `out_ready`=0 for 5 cycles after `out_valid` -> `out_data` stays 0x10C and `in_ready`=0 throughout; release -> IDLE next cycle.
- `flush` at round 6 -> IDLE next cycle, `out_valid` never rises. New `t`=0x200 then yields 0x20C.
- `rst_n` low during RUN at round 4 -> outputs return to reset values immediately (asynchronous); no stale `out_valid` after release.
- Back-to-back inputs with `in_valid` held high -> second acceptance exactly one cycle after the first output handshake; `in_valid` during RUN has no effect.

Source files
------------

// File: rtl/prince_pkg.sv
// prince_pkg: shared constants and FSM state encoding for the PRINCE round sequencer.
package prince_pkg;
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_ROUNDS = 12;
  localparam int DEF_CNT_W  = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/round_counter.sv
// round_counter: round index with clear, load-to-1, increment and terminal flag at ROUNDS-1.
module round_counter
  import prince_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear outranks load so an abort always lands on index 0
  always_comb cnt_d = clr_i ? '0 : load_i ? CNT_W'(1) : inc_i ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == CNT_W'(ROUNDS - 1);
endmodule

// File: rtl/prince_state_router.sv
// prince_state_router: sequences ROUNDS feedback iterations per encryption and
// steers each round result to the feedback register or the held output register.
module prince_state_router
  import prince_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] fb,
  output logic [CNT_W-1:0] round_idx,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
);
  state_e           state_q;
  logic [WIDTH-1:0] fb_q, out_data_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             run;
  assign run = state_q == ST_RUN;
  round_counter #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush | (run & last)),
    .load_i (state_q == ST_IDLE & in_valid),
    .inc_i  (run),
    .cnt_o  (cnt),
    .last_o (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fb_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          fb_q    <= d;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          fb_q <= d;
          if (last) begin
            out_data_q  <= d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  // decoded from registered state only, so no input reaches an output combinationally
  assign in_ready  = state_q == ST_IDLE;
  assign sel       = !run;
  assign round_idx = run ? cnt : '0;
  assign fb        = fb_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_prince_state_router.sv
// tb_prince_state_router: table-driven transactions, directed corner sequences and
// random traffic checked against a transaction-level reference model.
module tb_prince_state_router;
  localparam int ROUNDS = 12;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic        in_ready, sel, out_valid;
  logic [63:0] tin = '0, d, fb, out_data;
  logic [3:0]  round_idx;
  int          checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  logic        m_busy, m_done;
  int          m_n;
  logic [63:0] m_fb, m_out;

  prince_state_router dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .d(d), .fb(fb), .round_idx(round_idx), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush)
  );

  assign d = (sel ? tin : fb) + 64'd1;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_n = 0; m_fb = '0; m_out = '0;
  endtask

  // one encryption: accept t, ROUNDS increments, hold the result until handshake
  task automatic model_step();
    if (flush) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin m_busy = 1'b1; m_n = 0; m_fb = tin + 64'd1; end
    end else if (!m_done) begin
      m_n++;
      m_fb = m_fb + 64'd1;
      if (m_n == ROUNDS - 1) begin m_done = 1'b1; m_out = m_fb; end
    end else if (out_ready) begin
      m_busy = 1'b0; m_done = 1'b0;
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) model_step();
    #1;
    if (chk_en && rst_n) begin
      chk("m_in_ready", in_ready, !m_busy);
      chk("m_sel", sel, !(m_busy && !m_done));
      chk("m_round_idx", round_idx, (m_busy && !m_done) ? 64'(m_n + 1) : 64'd0);
      chk("m_out_valid", out_valid, m_done);
      chk("m_fb", fb, m_fb);
      chk("m_out_data", out_data, m_out);
    end
  end

  typedef struct { logic [63:0] t; int hold; logic [63:0] exp; } vec_t;
  vec_t vecs[4];

  task automatic run_txn(input logic [63:0] tv, input int hold, input logic [63:0] ev);
    int w, lat;
    @(negedge clk);
    tin = tv; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    chk("accept_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      if (out_valid) break;
      chk("run_round_idx", round_idx, 64'(lat + 1));
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, ROUNDS - 1);
    chk("out_data", out_data, ev);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", out_data, ev);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);
  endtask

  initial begin
    int acc[$], hs[$];
    int w;
    logic seen;
    model_reset();
    vecs[0] = '{64'h100, 0, 64'h10C};
    vecs[1] = '{64'h2A0, 5, 64'h2AC};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 1, 64'h4};
    vecs[3] = '{64'hDEAD_BEEF_0000_0000, 2, 64'hDEAD_BEEF_0000_000C};
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sel", sel, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fb", fb, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_round_idx", round_idx, 0);
    @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    foreach (vecs[i]) run_txn(vecs[i].t, vecs[i].hold, vecs[i].exp);

    // flush at round 6, with a competing input offer that must be refused
    @(negedge clk);
    tin = 64'h300; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (round_idx != 4'd6 && w < 40) begin @(negedge clk); w++; end
    chk("flush_reach_r6", round_idx, 6);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_round_idx", round_idx, 0);
    chk("flush_valid", out_valid, 0);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= out_valid; end
    chk("flush_no_valid", seen, 0);
    run_txn(64'h200, 0, 64'h20C);

    // asynchronous reset at round 4
    @(negedge clk);
    tin = 64'h400; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (round_idx != 4'd4 && w < 40) begin @(negedge clk); w++; end
    chk("rst_reach_r4", round_idx, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_sel", sel, 1);
    chk("arst_round_idx", round_idx, 0);
    chk("arst_fb", fb, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); seen |= out_valid; end
    chk("arst_no_stale_valid", seen, 0);

    // back-to-back with in_valid and out_ready held high
    tin = 64'h500; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (in_ready) acc.push_back(i);
      if (out_valid) hs.push_back(i);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_acc_count", acc.size(), 4);
    chk("b2b_hs_count", hs.size(), 3);
    chk("b2b_first_lat", hs[0] - acc[0], ROUNDS);
    chk("b2b_second_acc", acc[1], hs[0] + 1);
    chk("b2b_third_acc", acc[2], hs[1] + 1);
    chk("b2b_interval", acc[2] - acc[1], ROUNDS + 1);

    // random traffic against the model
    repeat (400) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      tin       = {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
